// File: rtl/mat_slot_store.sv
// -----------------------------------------------------------------------------
// mat_slot_store
//
// Two-slot matrix store. A row-major element stream is written into one of two
// slots; each slot remembers its dimensions and a valid bit. A read responder
// answers element requests with a fixed one-cycle latency.
//
// Optional feature macro: MAT_STORE_RD_CHECK_EN
//   defined   : reads of an invalid slot or outside the stored m x n bounds
//               return rd_elem = 0 with rd_err = 1.
//   undefined : reads return the raw memory word; rd_err is tied low.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   wr_start/wr_slot/wr_m/wr_n  fill request (taken only when wr_ready)
//   wr_ready                 write FSM idle
//   wr_busy                  fill in progress (FILL, DONE or ERROR)
//   wr_done / wr_error       one-cycle completion / rejection pulses
//   in_valid/in_elem/in_last element stream; in_ready high while filling
//   slot_valid               per-slot valid bits
//   slot0_m/n, slot1_m/n     stored dimensions
//   rd_en/rd_slot_idx/rd_row_idx/rd_col_idx  read request
//   rd_elem/rd_elem_valid/rd_err             read response, one cycle later
// -----------------------------------------------------------------------------
module mat_slot_store #(
    parameter int DIM_WIDTH  = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // fill control
    input  logic                  wr_start,
    input  logic                  wr_slot,
    input  logic [DIM_WIDTH-1:0]  wr_m,
    input  logic [DIM_WIDTH-1:0]  wr_n,
    output logic                  wr_ready,
    output logic                  wr_busy,
    output logic                  wr_done,
    output logic                  wr_error,
    // element stream
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_elem,
    input  logic                  in_last,
    output logic                  in_ready,
    // slot status
    output logic [1:0]            slot_valid,
    output logic [DIM_WIDTH-1:0]  slot0_m,
    output logic [DIM_WIDTH-1:0]  slot0_n,
    output logic [DIM_WIDTH-1:0]  slot1_m,
    output logic [DIM_WIDTH-1:0]  slot1_n,
    // read port
    input  logic                  rd_en,
    input  logic                  rd_slot_idx,
    input  logic [DIM_WIDTH-1:0]  rd_row_idx,
    input  logic [DIM_WIDTH-1:0]  rd_col_idx,
    output logic [DATA_WIDTH-1:0] rd_elem,
    output logic                  rd_elem_valid,
    output logic                  rd_err
);

    // Address is {slot, row, col}: the row stride is fixed at 2^DIM_WIDTH
    // regardless of the stored n, so no multiplier is needed.
    localparam int ADDR_W = 2 * DIM_WIDTH + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [DIM_WIDTH-1:0] DIM_ZERO = '0;
    localparam logic [DIM_WIDTH-1:0] DIM_ONE  = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_FILL  = 2'd1;
    localparam logic [1:0] W_DONE  = 2'd2;
    localparam logic [1:0] W_ERROR = 2'd3;

    // ------------------------------------------------------------------
    // Write FSM state
    // ------------------------------------------------------------------
    logic [1:0]           state_q, state_d;
    logic                 slot_q, slot_d;
    logic [DIM_WIDTH-1:0] m_q, m_d;
    logic [DIM_WIDTH-1:0] n_q, n_d;
    logic [DIM_WIDTH-1:0] row_q, row_d;
    logic [DIM_WIDTH-1:0] col_q, col_d;
    logic [1:0]           valid_q, valid_d;

    logic                 mem_we;
    logic                 commit;
    logic                 last_pos;
    logic                 col_wrap;
    logic [DIM_WIDTH-1:0] m_last;
    logic [DIM_WIDTH-1:0] n_last;

    assign m_last   = m_q - DIM_ONE;
    assign n_last   = n_q - DIM_ONE;
    assign col_wrap = (col_q == n_last);
    assign last_pos = (row_q == m_last) && col_wrap;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        m_d     = m_q;
        n_d     = n_q;
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        mem_we  = 1'b0;
        commit  = 1'b0;

        case (state_q)
            W_IDLE: begin
                if (wr_start) begin
                    slot_d          = wr_slot;
                    m_d             = wr_m;
                    n_d             = wr_n;
                    row_d           = DIM_ZERO;
                    col_d           = DIM_ZERO;
                    valid_d[wr_slot] = 1'b0;
                    if ((wr_m == DIM_ZERO) || (wr_n == DIM_ZERO)) begin
                        state_d = W_ERROR;
                    end else begin
                        state_d = W_FILL;
                    end
                end
            end

            W_FILL: begin
                if (in_valid) begin
                    // Every accepted element lands in memory, including the
                    // one that turns out to end the fill in error.
                    mem_we = 1'b1;
                    if (last_pos) begin
                        if (in_last) begin
                            // Commit dims/valid on entry to W_DONE so that
                            // slot_valid rises in the same cycle as wr_done.
                            state_d         = W_DONE;
                            commit          = 1'b1;
                            valid_d[slot_q] = 1'b1;
                        end else begin
                            state_d = W_ERROR;
                        end
                    end else if (in_last) begin
                        // Stream ended before m*n elements arrived.
                        state_d = W_ERROR;
                    end else if (col_wrap) begin
                        col_d = DIM_ZERO;
                        row_d = row_q + DIM_ONE;
                    end else begin
                        col_d = col_q + DIM_ONE;
                    end
                end
            end

            W_DONE:  state_d = W_IDLE;
            W_ERROR: state_d = W_IDLE;
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= W_IDLE;
            slot_q  <= 1'b0;
            m_q     <= '0;
            n_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 2'b00;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            m_q     <= m_d;
            n_q     <= n_d;
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
        end
    end

    assign wr_ready   = (state_q == W_IDLE);
    assign wr_busy    = (state_q != W_IDLE);
    assign wr_done    = (state_q == W_DONE);
    assign wr_error   = (state_q == W_ERROR);
    assign in_ready   = (state_q == W_FILL);
    assign slot_valid = valid_q;

    // ------------------------------------------------------------------
    // Per-slot stored dimensions, updated only on a successful commit
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [DIM_WIDTH-1:0] dim_m_q;
            logic [DIM_WIDTH-1:0] dim_n_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dim_m_q <= '0;
                    dim_n_q <= '0;
                end else if (commit && (slot_q == 1'(gi))) begin
                    dim_m_q <= m_q;
                    dim_n_q <= n_q;
                end
            end
        end
    endgenerate

    assign slot0_m = g_slot[0].dim_m_q;
    assign slot0_n = g_slot[0].dim_n_q;
    assign slot1_m = g_slot[1].dim_m_q;
    assign slot1_n = g_slot[1].dim_n_q;

    // ------------------------------------------------------------------
    // Element memory: one write port (fill), one registered read port.
    // A same-address read and write in one cycle returns the old word.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  rd_valid_q;

    assign wr_addr = {slot_q, row_q, col_q};
    assign rd_addr = {rd_slot_idx, rd_row_idx, rd_col_idx};

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= in_elem;
        end
    end

    // Output register only loads on a request, so rd_elem holds between
    // responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                ram_q <= mem[rd_addr];
            end
        end
    end

    assign rd_elem_valid = rd_valid_q;

`ifdef MAT_STORE_RD_CHECK_EN
    logic                 rd_invalid;
    logic                 rd_inv_q;
    logic [DIM_WIDTH-1:0] rd_dim_m;
    logic [DIM_WIDTH-1:0] rd_dim_n;

    assign rd_dim_m   = rd_slot_idx ? g_slot[1].dim_m_q : g_slot[0].dim_m_q;
    assign rd_dim_n   = rd_slot_idx ? g_slot[1].dim_n_q : g_slot[0].dim_n_q;
    assign rd_invalid = !valid_q[rd_slot_idx]
                     || (rd_row_idx >= rd_dim_m)
                     || (rd_col_idx >= rd_dim_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_inv_q <= 1'b0;
        end else if (rd_en) begin
            rd_inv_q <= rd_invalid;
        end
    end

    // Invalid reads are masked after the RAM so the read stays a plain
    // block-RAM access.
    assign rd_elem = rd_inv_q ? '0 : ram_q;
    assign rd_err  = rd_valid_q & rd_inv_q;
`else
    assign rd_elem = ram_q;
    assign rd_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mat_slot_store.sv
module tb_mat_slot_store;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_start;
    logic       wr_slot;
    logic [2:0] wr_m;
    logic [2:0] wr_n;
    logic       wr_ready;
    logic       wr_busy;
    logic       wr_done;
    logic       wr_error;
    logic       in_valid;
    logic [7:0] in_elem;
    logic       in_last;
    logic       in_ready;
    logic [1:0] slot_valid;
    logic [2:0] slot0_m, slot0_n, slot1_m, slot1_n;
    logic       rd_en;
    logic       rd_slot_idx;
    logic [2:0] rd_row_idx;
    logic [2:0] rd_col_idx;
    logic [7:0] rd_elem;
    logic       rd_elem_valid;
    logic       rd_err;

    mat_slot_store #(.DIM_WIDTH(3), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .wr_start(wr_start), .wr_slot(wr_slot), .wr_m(wr_m), .wr_n(wr_n),
        .wr_ready(wr_ready), .wr_busy(wr_busy), .wr_done(wr_done), .wr_error(wr_error),
        .in_valid(in_valid), .in_elem(in_elem), .in_last(in_last), .in_ready(in_ready),
        .slot_valid(slot_valid),
        .slot0_m(slot0_m), .slot0_n(slot0_n), .slot1_m(slot1_m), .slot1_n(slot1_n),
        .rd_en(rd_en), .rd_slot_idx(rd_slot_idx), .rd_row_idx(rd_row_idx),
        .rd_col_idx(rd_col_idx),
        .rd_elem(rd_elem), .rd_elem_valid(rd_elem_valid), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        bit         s;
        int         r;
        int         c;
        bit         inv;    // request is outside a valid slot/bounds
        bit         known;  // raw memory content is defined for this address
        logic [7:0] val;    // raw memory content
    } rvec_t;

    rvec_t tbl[9];

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("pass %s: %0h", name, act);
        end
    endtask

    function automatic logic [7:0] elem_of(input bit slot, input int k);
        return slot ? 8'(8'h80 + k) : 8'(k + 1);
    endfunction

    // Runs one fill. last_k is the element index carrying in_last. Reports
    // wr_done / wr_error as seen in the cycle right after the final accepted
    // element (or right after wr_start for a zero dimension).
    task automatic run_fill(input bit slot, input int m, input int n, input int last_k,
                            input bit gaps, input bit poke,
                            output bit done_seen, output bit err_seen);
        wr_start = 1'b1;
        wr_slot  = slot;
        wr_m     = 3'(m);
        wr_n     = 3'(n);
        tick();
        wr_start = 1'b0;
        if (m != 0 && n != 0) begin
            for (int k = 0; k < m * n; k++) begin
                if (gaps) repeat ($urandom_range(0, 2)) tick();
                in_valid = 1'b1;
                in_elem  = elem_of(slot, k);
                in_last  = (k == last_k);
                if (poke && k == 10) begin
                    // Start request while busy must be ignored.
                    wr_start = 1'b1;
                    wr_slot  = 1'b0;
                    wr_m     = 3'd0;
                end
                tick();
                in_valid = 1'b0;
                in_last  = 1'b0;
                wr_start = 1'b0;
                if (k == last_k) break;
            end
        end
        done_seen = wr_done;
        err_seen  = wr_error;
        tick();
    endtask

    task automatic read1(input bit s, input int r, input int c);
        rd_en       = 1'b1;
        rd_slot_idx = s;
        rd_row_idx  = 3'(r);
        rd_col_idx  = 3'(c);
        tick();
        rd_en = 1'b0;
    endtask

    bit   d_seen, e_seen;
    bit   fill_fin;
    int   rp, rcyc;
    logic [7:0] e_elem;
    bit   e_err;
    bit   e_known;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wr_start = 1'b0; wr_slot = 1'b0; wr_m = '0; wr_n = '0;
        in_valid = 1'b0; in_elem = '0; in_last = 1'b0;
        rd_en = 1'b0; rd_slot_idx = 1'b0; rd_row_idx = '0; rd_col_idx = '0;
        fill_fin = 1'b0;

        tbl[0] = '{1'b0, 0, 0, 1'b0, 1'b1, 8'd1};
        tbl[1] = '{1'b0, 1, 2, 1'b0, 1'b1, 8'd6};
        tbl[2] = '{1'b0, 0, 2, 1'b0, 1'b1, 8'd3};
        tbl[3] = '{1'b0, 1, 0, 1'b0, 1'b1, 8'd4};
        tbl[4] = '{1'b0, 2, 0, 1'b1, 1'b0, 8'd0};
        tbl[5] = '{1'b0, 0, 3, 1'b1, 1'b0, 8'd0};
        tbl[6] = '{1'b1, 0, 0, 1'b1, 1'b1, 8'h80};
        tbl[7] = '{1'b1, 1, 0, 1'b1, 1'b1, 8'h83};
        tbl[8] = '{1'b0, 1, 1, 1'b0, 1'b1, 8'd5};

        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_wr_busy", wr_busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_slot_valid", slot_valid, 0);
        chk("rst_dims", {slot0_m, slot0_n, slot1_m, slot1_n}, 0);
        chk("rst_rd", {rd_elem, rd_elem_valid, rd_err}, 0);
        chk("rst_pulses", {wr_done, wr_error}, 0);

        // Fill slot 0 with 2x3, elements 1..6
        run_fill(1'b0, 2, 3, 5, 1'b0, 1'b0, d_seen, e_seen);
        chk("fill0_done", d_seen, 1);
        chk("fill0_err", e_seen, 0);
        chk("fill0_ready", wr_ready, 1);
        chk("fill0_valid", slot_valid, 2'b01);
        chk("fill0_dims", {slot0_m, slot0_n}, {3'd2, 3'd3});

        // m = 0 on slot 1: rejected, slot_valid unchanged
        run_fill(1'b1, 0, 3, 0, 1'b0, 1'b0, d_seen, e_seen);
        chk("m0_err", e_seen, 1);
        chk("m0_done", d_seen, 0);
        chk("m0_valid", slot_valid, 2'b01);

        // 3x3 into slot 1 with in_last on the 4th element
        run_fill(1'b1, 3, 3, 3, 1'b0, 1'b0, d_seen, e_seen);
        chk("early_last_err", e_seen, 1);
        chk("early_last_done", d_seen, 0);
        chk("early_last_valid", slot_valid, 2'b01);
        chk("early_last_ready", wr_ready, 1);

        // Table of single reads
        for (int i = 0; i < 9; i++) begin
`ifdef MAT_STORE_RD_CHECK_EN
            e_elem  = tbl[i].inv ? 8'd0 : tbl[i].val;
            e_err   = tbl[i].inv;
            e_known = 1'b1;
`else
            e_elem  = tbl[i].val;
            e_err   = 1'b0;
            e_known = tbl[i].known;
`endif
            read1(tbl[i].s, tbl[i].r, tbl[i].c);
            chk($sformatf("tbl%0d_valid", i), rd_elem_valid, 1);
            chk($sformatf("tbl%0d_err", i), rd_err, e_err);
            if (e_known) chk($sformatf("tbl%0d_elem", i), rd_elem, e_elem);
        end

        // Six back-to-back reads of slot 0
        for (int i = 0; i < 6; i++) begin
            rd_en       = 1'b1;
            rd_slot_idx = 1'b0;
            rd_row_idx  = 3'(i / 3);
            rd_col_idx  = 3'(i % 3);
            tick();
            chk($sformatf("b2b%0d", i), {rd_elem_valid, rd_elem}, {1'b1, 8'(i + 1)});
        end
        rd_en = 1'b0;
        tick();
        chk("hold_elem", {rd_elem_valid, rd_elem}, {1'b0, 8'd6});

        // 7x7 fill of slot 1 with gaps while slot 0 is read every cycle
        rp = 0;
        rcyc = 0;
        fork
            begin
                run_fill(1'b1, 7, 7, 48, 1'b1, 1'b1, d_seen, e_seen);
                fill_fin = 1'b1;
            end
            begin
                while (!fill_fin && rcyc < 2000) begin
                    rd_en       = 1'b1;
                    rd_slot_idx = 1'b0;
                    rd_row_idx  = 3'(rp / 3);
                    rd_col_idx  = 3'(rp % 3);
                    tick();
                    chk("cread", {rd_elem_valid, rd_err, rd_elem}, {1'b1, 1'b0, 8'(rp + 1)});
                    rp = (rp + 1) % 6;
                    rcyc++;
                end
                rd_en = 1'b0;
            end
        join
        chk("fill77_done", d_seen, 1);
        chk("fill77_err", e_seen, 0);
        chk("fill77_valid", slot_valid, 2'b11);
        chk("fill77_dims", {slot1_m, slot1_n}, {3'd7, 3'd7});
        chk("fill77_slot0_dims", {slot0_m, slot0_n}, {3'd2, 3'd3});
        for (int k = 0; k < 49; k++) begin
            read1(1'b1, k / 7, k % 7);
            chk($sformatf("s1_%0d", k), {rd_elem_valid, rd_err, rd_elem},
                {1'b1, 1'b0, 8'(8'h80 + k)});
        end

        // Reset in the middle of a fill
        wr_start = 1'b1; wr_slot = 1'b0; wr_m = 3'd2; wr_n = 3'd3;
        tick();
        wr_start = 1'b0;
        chk("mid_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_elem  = 8'(k + 1);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", wr_ready, 1);
        chk("mid_rst_valid", slot_valid, 2'b00);
        chk("mid_rst_in_ready", in_ready, 0);

        run_fill(1'b0, 2, 3, 5, 1'b0, 1'b0, d_seen, e_seen);
        chk("refill_done", d_seen, 1);
        chk("refill_valid", slot_valid, 2'b01);
        read1(1'b0, 1, 1);
        chk("refill_read", {rd_elem_valid, rd_err, rd_elem}, {1'b1, 1'b0, 8'd5});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mat_slot_store.md
# mat_slot_store

Two-slot matrix storage block that serves as the responder for the element read port used by the matrix operation units (scalar multiply, add, transpose). It accepts a row-major element stream into a selected slot, records the slot's dimensions and validity, and answers `rd_en` requests with a fixed one-cycle-latency `rd_elem`/`rd_elem_valid` response. It sits between the input/result-writeback path and every operation unit's read interface.

## Interface
- `DIM_WIDTH`, 3, dimension index width; maximum rows/cols = 2^DIM_WIDTH−1 (7).
- `DATA_WIDTH`, 8, element width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wr_start`  in  1  begin filling a slot; accepted only when `wr_ready`=1.
- `wr_slot`  in  1  target slot for the fill.
- `wr_m`, `wr_n`  in  DIM_WIDTH each  rows and cols of the incoming matrix.
- `wr_ready`  out  1  write FSM idle.
- `wr_busy`  out  1  fill in progress.
- `wr_done`  out  1  one-cycle pulse: fill completed, slot now valid.
- `wr_error`  out  1  one-cycle pulse: fill rejected or aborted.
- `in_valid`  in  1  stream element present.
- `in_elem`  in  DATA_WIDTH  stream element, row-major.
- `in_last`  in  1  marks final element of the stream.
- `in_ready`  out  1  high in W_FILL only; the element is taken when `in_valid`&&`in_ready`.
- `slot_valid`  out  2  per-slot valid bits.
- `slot0_m`, `slot0_n`, `slot1_m`, `slot1_n`  out  DIM_WIDTH each  stored dimensions.
- `rd_en`  in  1  read request.
- `rd_slot_idx`  in  1; `rd_row_idx`, `rd_col_idx`  in  DIM_WIDTH each  read address.
- `rd_elem`  out  DATA_WIDTH  read data.
- `rd_elem_valid`  out  1  one-cycle pulse accompanying `rd_elem`.
- `rd_err`  out  1  pulse with `rd_elem_valid` when the request was invalid.

## Operation
- Storage: 2 × 2^(2·DIM_WIDTH) words. Address = {slot, row, col`}`, giving a fixed row stride of 2^DIM_WIDTH. The memory is not cleared by reset.
- Write FSM states are W_IDLE, W_FILL, W_DONE and W_ERROR.
  - W_IDLE: `wr_ready`=1. When `wr_start` is high, the block latches slot, m and n, clears `slot_valid[wr_slot]`, and zeroes the row/col counters. The FSM goes to W_ERROR if `wr_m`==0 or `wr_n`==0; otherwise it goes to W_FILL.
  - W_FILL: each accepted element is written at {slot,row,col}. Col increments; when col==n−1, col wraps to 0 and row increments.
  - On the element where row==m−1 and col==n−1: if `in_last`=1 the FSM goes to W_DONE. If `in_last`=0 it goes to W_ERROR.
  - `in_last`=1 on any earlier element sends the FSM to W_ERROR.
  - W_DONE: the block writes the stored m/n, sets `slot_valid[slot]`, pulses `wr_done`, and returns to W_IDLE.
  - W_ERROR: pulses `wr_error`, leaves the slot invalid, and returns to W_IDLE.
  - `wr_busy`=1 in W_FILL, W_DONE and W_ERROR.
- Read responder:
  - When `rd_en` is high, the block registers the addressed word.
  - The next cycle it drives `rd_elem_valid`=1 and `rd_elem`=data.
  - Back-to-back `rd_en` gives back-to-back responses.
- Read during fill of the same slot: the slot is invalid, so the request is treated as an invalid read (see Configuration).
- Read and write to different slots in the same cycle proceed independently.
- A same-address read/write collision returns the old data.

## Timing
- Reset values: `wr_ready`=1. All other outputs are 0: `slot_valid`=2'b00, all dims 0, `rd_elem`=0, all pulses 0, `in_ready`=0.
- Reset mid-fill returns the FSM to W_IDLE and invalidates both slots.
- Fill latency: `wr_start` → W_FILL at the next edge. After the final element is accepted, `wr_done` and `slot_valid` are high one cycle later.
- Minimum fill time is m·n+2 cycles.
- `in_valid` may gap freely in W_FILL; the counters advance only on accepted elements.
- `wr_start` while not in W_IDLE is ignored.
- Read latency is exactly 1 cycle. `rd_elem` holds its value until the next response.

## Configuration
- `MAT_STORE_RD_CHECK_EN` defined:
  - A read is invalid if the slot is not valid, row ≥ stored m, or col ≥ stored n.
  - An invalid read returns `rd_elem`=0 with `rd_elem_valid`=1 and `rd_err`=1.
- Undefined:
  - Reads return the raw memory word regardless of validity or bounds.
  - `rd_err` is tied to 0.

## Test plan
- Reset, then fill slot 0 with m=2, n=3 using elements 1..6 and `in_last` on the 6th → `wr_done` pulse, `slot_valid`=01, `slot0_m`=2, `slot0_n`=3.
- Read slot 0 at (1,2) → one cycle later `rd_elem`=6 and `rd_elem_valid`=1. Six back-to-back reads → six consecutive responses 1..6.
- `wr_start` with m=0 → `wr_error` pulse and `slot_valid` unchanged. Fill 3×3 with `in_last` on the 4th element → `wr_error`, slot invalid.
- With `MAT_STORE_RD_CHECK_EN` defined, read slot 1 (invalid) or slot 0 at (2,0) → `rd_elem`=0, `rd_err`=1. With the macro undefined, the same reads give `rd_err`=0.
- Fill a 7×7 matrix into slot 1 with random `in_valid` gaps while reading slot 0 continuously → all 49 elements are stored correctly and slot 0 reads are unaffected.
- Assert `rst` after 3 of 6 fill elements → `wr_ready`=1, `slot_valid`=00. A subsequent full fill succeeds.
